// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with boot hold, stall, redirect, trap/mret and EPC
module pc_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int               IALIGN       = 4,
    parameter int               BOOT_DELAY   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_Plus,
    output logic            fetch_valid,
    output logic [XLEN-1:0] EPC,
    output logic            misaligned
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic            target_misaligned;

    assign target_misaligned = (IALIGN == 2) ? redirect_target[0] : |redirect_target[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_d  = RESET_VECTOR;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Flush sources outrank the hazard hold.
                if (trap_valid) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = trap_pc;
                end else if (mret_valid) begin
                    pc_d = epc_q;
                end else if (redirect_valid && !target_misaligned) begin
                    pc_d = redirect_target;
                end else if (redirect_valid) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = redirect_target;
                    mis_d = 1'b1;
                end else if (!stall) begin
                    pc_d = PC_Plus;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = 4'd0;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign PC          = pc_q;
    assign PC_Plus     = pc_q + XLEN'(IALIGN);
    assign fetch_valid = (state_q == ST_RUN);
    assign EPC         = epc_q;
    assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - table-driven bench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, rv, tv, mv;
    logic [31:0] rt, tpc;

    logic [31:0] pc, plus, epc;
    logic        fv, mis;
    logic [31:0] pc2, plus2, epc2;
    logic        fv2, mis2;
    logic [15:0] pc3, plus3, epc3;
    logic        fv3, mis3;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
        .trap_valid(tv), .trap_pc(tpc), .mret_valid(mv),
        .PC(pc), .PC_Plus(plus), .fetch_valid(fv), .EPC(epc), .misaligned(mis)
    );

    pc_unit #(.IALIGN(2)) u_ia2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
        .trap_valid(tv), .trap_pc(tpc), .mret_valid(mv),
        .PC(pc2), .PC_Plus(plus2), .fetch_valid(fv2), .EPC(epc2), .misaligned(mis2)
    );

    pc_unit #(.XLEN(16), .RESET_VECTOR(16'h8000), .TRAP_VECTOR(16'h0100)) u_x16 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt[15:0]),
        .trap_valid(tv), .trap_pc(tpc[15:0]), .mret_valid(mv),
        .PC(pc3), .PC_Plus(plus3), .fetch_valid(fv3), .EPC(epc3), .misaligned(mis3)
    );

    typedef struct {
        logic        stall, rv, tv, mv;
        logic [31:0] rt, tpc;
        logic [31:0] e_pc, e_plus, e_epc;
        logic        e_fv, e_mis;
        logic        alt;
        logic [31:0] alt_pc;
    } vec_t;

    vec_t vecs[18];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic tr, input logic [31:0] tp, input logic m,
                                input logic [31:0] ep, input logic f, input logic [31:0] ee,
                                input logic mi);
        vec_t v;
        v.stall = s; v.rv = r; v.rt = t; v.tv = tr; v.tpc = tp; v.mv = m;
        v.e_pc = ep; v.e_plus = ep + 32'd4; v.e_fv = f; v.e_epc = ee; v.e_mis = mi;
        v.alt = 1'b0; v.alt_pc = 32'h0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; rv = 0; tv = 0; mv = 0; rt = 32'h0; tpc = 32'h0;
    endtask

    initial begin
        //                s  rv target        tv trap_pc      mv  PC            fv EPC           mis
        vecs[0]  = mk(1'b0, 1, 32'h0000_0040, 1, 32'h0000_0044, 1, 32'h0000_0000, 0, 32'h0000_0000, 0);
        vecs[1]  = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 1, 32'h0000_0000, 0);
        vecs[2]  = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0004, 1, 32'h0000_0000, 0);
        vecs[3]  = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0000, 0);
        vecs[4]  = mk(1'b1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0000, 0);
        vecs[5]  = mk(1'b1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0000, 0);
        vecs[6]  = mk(1'b1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0000, 0);
        vecs[7]  = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_000C, 1, 32'h0000_0000, 0);
        vecs[8]  = mk(1'b1, 1, 32'h0000_0040, 0, 32'h0,         0, 32'h0000_0040, 1, 32'h0000_0000, 0);
        vecs[9]  = mk(1'b0, 1, 32'h0000_1000, 0, 32'h0,         0, 32'h0000_1000, 1, 32'h0000_0000, 0);
        vecs[10] = mk(1'b0, 0, 32'h0,         1, 32'h0000_1004, 0, 32'h0000_0100, 1, 32'h0000_1004, 0);
        vecs[11] = mk(1'b0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_1004, 1, 32'h0000_1004, 0);
        vecs[12] = mk(1'b0, 0, 32'h0,         1, 32'h0000_2000, 1, 32'h0000_0100, 1, 32'h0000_2000, 0);
        vecs[13] = mk(1'b0, 1, 32'h0000_2002, 0, 32'h0,         0, 32'h0000_0100, 1, 32'h0000_2002, 1);
        vecs[13].alt = 1'b1; vecs[13].alt_pc = 32'h0000_2002;
        vecs[14] = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 1, 32'h0000_2002, 0);
        vecs[15] = mk(1'b0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0000_2002, 0);
        vecs[16] = mk(1'b0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 1, 32'h0000_2002, 0);
        vecs[17] = mk(1'b0, 1, 32'h0000_003C, 0, 32'h0,         0, 32'h0000_003C, 1, 32'h0000_2002, 0);

        idle();
        rst = 1'b1;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_fv", {31'h0, fv}, 32'h0);
        chk("rst_mis", {31'h0, mis}, 32'h0);
        chk("rst_pc_x16", {16'h0, pc3}, 32'h8000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot0_pc", pc, 32'h0);
        chk("boot0_fv", {31'h0, fv}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].stall; rv = vecs[i].rv; rt = vecs[i].rt;
            tv = vecs[i].tv; tpc = vecs[i].tpc; mv = vecs[i].mv;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_plus", i), plus, vecs[i].e_plus);
            chk($sformatf("v%0d_fv", i), {31'h0, fv}, {31'h0, vecs[i].e_fv});
            chk($sformatf("v%0d_epc", i), epc, vecs[i].e_epc);
            chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, vecs[i].e_mis});
            if (vecs[i].alt) begin
                chk($sformatf("v%0d_ia2_pc", i), pc2, vecs[i].alt_pc);
                chk($sformatf("v%0d_ia2_plus", i), plus2, vecs[i].alt_pc + 32'd2);
                chk($sformatf("v%0d_ia2_mis", i), {31'h0, mis2}, 32'h0);
            end
            @(negedge clk);
        end
        idle();

        // asynchronous reset between edges while running at 0x3C
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_fv", {31'h0, fv}, 32'h0);
        chk("arst_epc", epc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reboot0_fv", {31'h0, fv}, 32'h0);
        @(posedge clk);
        #1;
        chk("reboot1_pc", pc, 32'h0);
        chk("reboot1_fv", {31'h0, fv}, 32'h0);
        @(posedge clk);
        #1;
        chk("reboot2_pc", pc, 32'h0);
        chk("reboot2_fv", {31'h0, fv}, 32'h1);
        chk("x16_run_pc", {16'h0, pc3}, 32'h8000);
        chk("x16_run_fv", {31'h0, fv3}, 32'h1);
        @(posedge clk);
        #1;
        chk("reboot3_pc", pc, 32'h4);
        chk("x16_step_pc", {16'h0, pc3}, 32'h8004);
        chk("x16_step_plus", {16'h0, plus3}, 32'h8008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
